program_mem_loader: RTL and testbench

- Parametrised, run-time-loadable successor to the fixed instruction ROM.
- Holds DEPTH words of DATA_W-bit instructions in on-chip RAM.
- A streaming loader port fills the memory from address 0 with a valid/ready handshake.
- The processor fetch port has registered 1-cycle read latency, stalls while loading, and returns a fill (NOP) word for any address at or beyond the loaded program length.

---
 rtl/program_mem_loader_if.sv | 41 ++++
 rtl/program_mem_loader.sv | 127 ++++++++++++
 tb/tb_program_mem_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_mem_loader_if.sv
// Loader stream and fetch port bundle
// for the run-time loadable program memory.
interface program_mem_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              ld_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic [ADDR_W:0]   prog_len;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [DATA_W-1:0] instruction;
  logic              fetch_oob;

  modport master (
    output ld_start, ld_len,
    output ld_valid, ld_data,
    input  ld_ready, ld_busy,
    input  ld_done, prog_len,
    output fetch_req, fetch_addr,
    input  fetch_stall, fetch_valid,
    input  instruction, fetch_oob
  );

  modport slave (
    input  ld_start, ld_len,
    input  ld_valid, ld_data,
    output ld_ready, ld_busy,
    output ld_done, prog_len,
    input  fetch_req, fetch_addr,
    output fetch_stall, fetch_valid,
    output instruction, fetch_oob
  );
endinterface

// File: rtl/program_mem_loader.sv
// Loadable instruction RAM: streaming loader
// plus 1-cycle fetch port with NOP fill past prog_len.
module program_mem_loader #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  program_mem_loader_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE =
    (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_READY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   plen_q, plen_d;
  logic              done_q, done_d;
  logic              we;
  logic [ADDR_W:0]   len_clip;
  logic              fetch_acc;
  logic              in_range;
  logic              fv_q;
  logic              oob_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    len_clip = bus.ld_len;
    if (bus.ld_len > DEPTH_L) len_clip = DEPTH_L;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    plen_d  = plen_q;
    done_d  = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      S_EMPTY, S_READY: begin
        if (bus.ld_start) begin
          len_d  = len_clip;
          ptr_d  = '0;
          plen_d = '0;
          if (len_clip == '0) begin
            state_d = S_READY;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (bus.ld_valid) begin
          we     = 1'b1;
          ptr_d  = ptr_q + ONE;
          plen_d = ptr_q + ONE;
          if (ptr_q == len_q - ONE) begin
            state_d = S_READY;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      len_q   <= '0;
      ptr_q   <= '0;
      plen_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      plen_q  <= plen_d;
      done_q  <= done_d;
    end
  end

  // RAM content is never reset; prog_len gates visibility.
  always_ff @(posedge clk) begin
    if (we) mem[ptr_q[ADDR_W-1:0]] <= bus.ld_data;
  end

  assign fetch_acc = bus.fetch_req &&
                     (state_q != S_LOAD);
  assign in_range  = {1'b0, bus.fetch_addr} < plen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q    <= 1'b0;
      oob_q   <= 1'b0;
      instr_q <= FILL_WORD;
    end else begin
      fv_q <= fetch_acc;
      if (fetch_acc) begin
        oob_q   <= !in_range;
        instr_q <= in_range ? mem[bus.fetch_addr]
                            : FILL_WORD;
      end
    end
  end

  assign bus.ld_ready    = (state_q == S_LOAD);
  assign bus.ld_busy     = (state_q == S_LOAD);
  assign bus.fetch_stall = (state_q == S_LOAD);
  assign bus.ld_done     = done_q;
  assign bus.prog_len    = plen_q;
  assign bus.fetch_valid = fv_q;
  assign bus.instruction = instr_q;
  assign bus.fetch_oob   = oob_q;
endmodule

// File: tb/tb_program_mem_loader.sv
// Randomised bench for program_mem_loader against
// an array model of loaded words and program length.
module tb_program_mem_loader;
  localparam logic [15:0] FILL = 16'h0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [15:0] mem_m [16];
  int          plen_m = 0;
  logic [15:0] wbuf [16];

  always #5 clk = ~clk;

  program_mem_loader_if #(
    .DATA_W(16), .ADDR_W(4)) ifc ();

  program_mem_loader #(
    .DATA_W(16), .ADDR_W(4),
    .FILL_WORD(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  function automatic logic [15:0] exp_word(int a);
    return (a < plen_m) ? mem_m[a] : FILL;
  endfunction

  task automatic test_reset();
    ifc.ld_start = 0; ifc.ld_len = 0;
    ifc.ld_valid = 0; ifc.ld_data = 0;
    ifc.fetch_req = 0; ifc.fetch_addr = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if (ifc.ld_ready !== 0 || ifc.ld_busy !== 0 ||
        ifc.ld_done !== 0 || ifc.prog_len !== 0 ||
        ifc.fetch_valid !== 0 || ifc.fetch_oob !== 0 ||
        ifc.instruction !== FILL ||
        ifc.fetch_stall !== 0) begin
      bad++;
      $display("FAIL reset rdy=%b busy=%b done=%b len=%0d fv=%b oob=%b ins=%h stall=%b",
        ifc.ld_ready, ifc.ld_busy, ifc.ld_done,
        ifc.prog_len, ifc.fetch_valid, ifc.fetch_oob,
        ifc.instruction, ifc.fetch_stall);
    end
    rst_n = 1;
    plen_m = 0;
  endtask

  task automatic fetch_run(input int first,
                           input int n,
                           input bit rnd);
    int a [$];
    logic [15:0] last;
    for (int i = 0; i < n; i++)
      a.push_back(rnd ? int'($urandom_range(0, 15))
                      : first + i);
    last = ifc.instruction;
    for (int i = 0; i < n; i++) begin
      total++;
      if (ifc.fetch_stall !== 0) begin
        bad++;
        $display("FAIL fetch_stall got=%b want=0",
          ifc.fetch_stall);
      end
      ifc.fetch_req = 1;
      ifc.fetch_addr = 4'(a[i]);
      @(negedge clk);
      last = exp_word(a[i]);
      total++;
      if (ifc.fetch_valid !== 1 ||
          ifc.instruction !== last ||
          ifc.fetch_oob !== (a[i] >= plen_m)) begin
        bad++;
        $display("FAIL fetch a=%0d fv=%b ins=%h oob=%b want ins=%h oob=%b",
          a[i], ifc.fetch_valid, ifc.instruction,
          ifc.fetch_oob, last, a[i] >= plen_m);
      end
    end
    ifc.fetch_req = 0;
    @(negedge clk);
    total++;
    if (ifc.fetch_valid !== 0 ||
        ifc.instruction !== last) begin
      bad++;
      $display("FAIL fetch_idle fv=%b ins=%h want 0 %h",
        ifc.fetch_valid, ifc.instruction, last);
    end
  endtask

  task automatic stream(input int len,
                        input int gap_at,
                        input int gap_n);
    int i = 0;
    int g = gap_n;
    int cyc = 0;
    while (i < len && cyc < 300) begin
      total++;
      if (ifc.ld_busy !== 1 || ifc.ld_ready !== 1 ||
          ifc.fetch_stall !== 1 ||
          ifc.ld_done !== 0) begin
        bad++;
        $display("FAIL load_flags i=%0d busy=%b rdy=%b stall=%b done=%b",
          i, ifc.ld_busy, ifc.ld_ready,
          ifc.fetch_stall, ifc.ld_done);
      end
      ifc.ld_start = ($urandom_range(0, 3) == 0);
      ifc.ld_len = 5'($urandom);
      if (i == gap_at && g > 0) begin
        ifc.ld_valid = 0;
        g--;
      end else begin
        ifc.ld_valid = 1;
        ifc.ld_data = wbuf[i];
        mem_m[i] = wbuf[i];
        i++;
        plen_m = i;
      end
      @(negedge clk);
      cyc++;
    end
    ifc.ld_valid = 0;
    ifc.ld_start = 0;
    total++;
    if (cyc >= 300) begin
      bad++;
      $display("FAIL load_timeout got=%0d want=%0d",
        i, len);
    end
    total++;
    if (ifc.ld_done !== 1 || ifc.ld_busy !== 0 ||
        ifc.ld_ready !== 0 ||
        ifc.prog_len !== 5'(len)) begin
      bad++;
      $display("FAIL load_end done=%b busy=%b rdy=%b len=%0d want 1 0 0 %0d",
        ifc.ld_done, ifc.ld_busy, ifc.ld_ready,
        ifc.prog_len, len);
    end
    @(negedge clk);
    total++;
    if (ifc.ld_done !== 0) begin
      bad++;
      $display("FAIL done_pulse got=%b want=0",
        ifc.ld_done);
    end
  endtask

  task automatic do_load(input int n,
                         input int gap_at,
                         input int gap_n);
    int len = (n > 16) ? 16 : n;
    ifc.ld_start = 1;
    ifc.ld_len = 5'(n);
    @(negedge clk);
    ifc.ld_start = 0;
    plen_m = 0;
    if (len == 0) begin
      total++;
      if (ifc.ld_done !== 1 || ifc.ld_busy !== 0 ||
          ifc.prog_len !== 0) begin
        bad++;
        $display("FAIL zero_len done=%b busy=%b len=%0d want 1 0 0",
          ifc.ld_done, ifc.ld_busy, ifc.prog_len);
      end
      @(negedge clk);
      total++;
      if (ifc.ld_done !== 0) begin
        bad++;
        $display("FAIL zero_pulse got=%b want=0",
          ifc.ld_done);
      end
    end else begin
      stream(len, gap_at, gap_n);
    end
  endtask

  task automatic test_basic_load();
    wbuf[0] = 16'h1202; wbuf[1] = 16'hF200;
    wbuf[2] = 16'h0200; wbuf[3] = 16'h1405;
    wbuf[4] = 16'hF400;
    do_load(5, 2, 2);
    fetch_run(0, 5, 0);
    fetch_run(5, 1, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++)
      wbuf[i] = 16'($urandom);
    do_load(17, $urandom_range(0, 15), 1);
    ifc.ld_valid = 1;
    ifc.ld_data = 16'hDEAD;
    total++;
    if (ifc.ld_ready !== 0) begin
      bad++;
      $display("FAIL ovf_ready got=%b want=0",
        ifc.ld_ready);
    end
    @(negedge clk);
    ifc.ld_valid = 0;
    total++;
    if (ifc.prog_len !== 5'd16) begin
      bad++;
      $display("FAIL ovf_len got=%0d want=16",
        ifc.prog_len);
    end
    fetch_run(15, 1, 0);
    fetch_run(0, 16, 0);
  endtask

  task automatic test_concurrent();
    logic [15:0] old;
    old = exp_word(1);
    ifc.ld_start = 1;
    ifc.ld_len = 5'd4;
    ifc.fetch_req = 1;
    ifc.fetch_addr = 4'd1;
    @(negedge clk);
    ifc.ld_start = 0;
    ifc.fetch_addr = 4'd0;
    plen_m = 0;
    total++;
    if (ifc.fetch_valid !== 1 ||
        ifc.instruction !== old ||
        ifc.fetch_oob !== 0 ||
        ifc.fetch_stall !== 1) begin
      bad++;
      $display("FAIL concur fv=%b ins=%h oob=%b stall=%b want 1 %h 0 1",
        ifc.fetch_valid, ifc.instruction,
        ifc.fetch_oob, ifc.fetch_stall, old);
    end
    @(negedge clk);
    ifc.fetch_req = 0;
    total++;
    if (ifc.fetch_valid !== 0) begin
      bad++;
      $display("FAIL stall_fetch fv=%b want=0",
        ifc.fetch_valid);
    end
    for (int i = 0; i < 4; i++)
      wbuf[i] = 16'($urandom);
    stream(4, 1, 1);
    fetch_run(0, 6, 0);
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 4; i++)
      wbuf[i] = 16'($urandom);
    ifc.ld_start = 1;
    ifc.ld_len = 5'd4;
    @(negedge clk);
    ifc.ld_start = 0;
    for (int i = 0; i < 2; i++) begin
      ifc.ld_valid = 1;
      ifc.ld_data = wbuf[i];
      @(negedge clk);
    end
    ifc.ld_valid = 0;
    #2 rst_n = 0;
    #1;
    plen_m = 0;
    total++;
    if (ifc.ld_busy !== 0 || ifc.prog_len !== 0 ||
        ifc.ld_ready !== 0 ||
        ifc.fetch_stall !== 0) begin
      bad++;
      $display("FAIL mid_reset busy=%b len=%0d rdy=%b stall=%b",
        ifc.ld_busy, ifc.prog_len,
        ifc.ld_ready, ifc.fetch_stall);
    end
    @(negedge clk);
    rst_n = 1;
    fetch_run(0, 1, 0);
  endtask

  task automatic test_zero_len();
    do_load(0, 0, 0);
    fetch_run(0, 2, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int n = $urandom_range(0, 17);
      for (int i = 0; i < 16; i++)
        wbuf[i] = 16'($urandom);
      do_load(n, $urandom_range(0, 16),
              $urandom_range(0, 3));
      fetch_run(0, 12, 1);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    fetch_run(3, 1, 0);
    test_basic_load();
    test_overflow();
    test_concurrent();
    test_reset_midload();
    test_basic_load();
    test_zero_len();
    test_random();
    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end
endmodule
